regfile_arbiter: RTL and testbench

Two-requester round-robin arbiter and access sequencer for the single-read/single-write-port register file (2-bit address, 32-bit data, 4 entries). It accepts a read or write command from requester A or B and drives the register file's R_Addr/W_Addr/R_en/W_en/W_Data for exactly one cycle. It then captures R_Data for reads and returns a one-cycle ack to the winning requester. It sits between the datapath's two register-file clients and the register file instance.

---
 rtl/regfile_arbiter.sv | 72 +++++++
 tb/tb_regfile_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester round-robin arbiter sequencing single-cycle register-file accesses
module regfile_arbiter #(
    parameter int A_WIDTH = 2,
    parameter int D_WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [A_WIDTH-1:0] a_addr,
    input  logic [D_WIDTH-1:0] a_wdata,
    output logic               a_ack,
    output logic [D_WIDTH-1:0] a_rdata,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [A_WIDTH-1:0] b_addr,
    input  logic [D_WIDTH-1:0] b_wdata,
    output logic               b_ack,
    output logic [D_WIDTH-1:0] b_rdata,
    output logic [A_WIDTH-1:0] rf_R_Addr,
    output logic [A_WIDTH-1:0] rf_W_Addr,
    output logic               rf_R_en,
    output logic               rf_W_en,
    output logic [D_WIDTH-1:0] rf_W_Data,
    input  logic [D_WIDTH-1:0] rf_R_Data,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic ptr, win, cmd_we, grant_b, start;
    logic [A_WIDTH-1:0] cmd_addr;
    logic [D_WIDTH-1:0] cmd_wdata;
    // ptr=1 means B has priority when both request
    assign grant_b = b_req & (~a_req | ptr);
    assign start = (state == IDLE) & (a_req | b_req);
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ptr       <= 1'b0;
            win       <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            if (start) begin
                win       <= grant_b;
                ptr       <= ~grant_b;
                cmd_we    <= grant_b ? b_we : a_we;
                cmd_addr  <= grant_b ? b_addr : a_addr;
                cmd_wdata <= grant_b ? b_wdata : a_wdata;
            end
            if (state == ACCESS && !cmd_we && !win) a_rdata <= rf_R_Data;
            if (state == ACCESS && !cmd_we && win) b_rdata <= rf_R_Data;
        end
    end
    always_comb begin
        state_nx  = state == IDLE ? (start ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
        rf_W_en   = state == ACCESS && cmd_we;
        rf_R_en   = state == ACCESS && !cmd_we;
        rf_W_Addr = rf_W_en ? cmd_addr : '0;
        rf_W_Data = rf_W_en ? cmd_wdata : '0;
        rf_R_Addr = rf_R_en ? cmd_addr : '0;
        a_ack     = state == RESP && !win;
        b_ack     = state == RESP && win;
        busy      = state != IDLE;
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed stimulus with a queue scoreboard checked by an ack monitor
module tb_regfile_arbiter;
    logic Clk = 0, Rst = 0;
    logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [1:0] a_addr = 0, b_addr = 0, rf_R_Addr, rf_W_Addr;
    logic [31:0] a_wdata = 0, b_wdata = 0, a_rdata, b_rdata, rf_W_Data, rf_R_Data;
    logic a_ack, b_ack, rf_R_en, rf_W_en, busy;
    int checks = 0, failures = 0;
    typedef struct {logic who; logic [31:0] a; logic [31:0] b;} exp_t;
    exp_t sb[$];
    logic [31:0] mem[4], sh[4], exp_a = 0, exp_b = 0;

    regfile_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .rf_R_Addr(rf_R_Addr), .rf_W_Addr(rf_W_Addr), .rf_R_en(rf_R_en), .rf_W_en(rf_W_en),
        .rf_W_Data(rf_W_Data), .rf_R_Data(rf_R_Data), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // register file model; a marker pattern stands in for high-Z when not reading
    initial for (int i = 0; i < 4; i++) begin mem[i] = 32'h11 * i; sh[i] = 32'h11 * i; end
    always @(posedge Clk) if (rf_W_en) mem[rf_W_Addr] <= rf_W_Data;
    assign rf_R_Data = rf_R_en ? mem[rf_R_Addr] : 32'hBAD0_BAD0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge Clk) begin : mon
        exp_t e;
        if (rf_R_en && rf_W_en) chk("rf_en_exclusive", {rf_R_en, rf_W_en}, 2'b00);
        if (a_ack || b_ack) begin
            if (sb.size() == 0) chk("unexpected_ack", {a_ack, b_ack}, 2'b00);
            else begin
                e = sb.pop_front();
                chk("ack_owner", {a_ack, b_ack}, e.who ? 2'b01 : 2'b10);
                chk("a_rdata", a_rdata, e.a);
                chk("b_rdata", b_rdata, e.b);
            end
        end
    end

    // starts just after a rising edge with the DUT idle; returns at the same point
    task automatic txn(input logic who, input logic we, input logic [1:0] addr, input logic [31:0] d);
        if (who) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = d; end
        else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = d; end
        if (we) sh[addr] = d;
        else if (who) exp_b = sh[addr];
        else exp_a = sh[addr];
        sb.push_back('{who, exp_a, exp_b});
        @(negedge Clk);
        @(negedge Clk);
        chk("access_en", {rf_W_en, rf_R_en}, {we, !we});
        if (we) chk("access_wr", {rf_W_Addr, rf_W_Data, rf_R_Addr}, {addr, d, 2'b00});
        else chk("access_rd", {rf_R_Addr, rf_W_Addr, rf_W_Data}, {addr, 2'b00, 32'h0});
        @(negedge Clk);
        @(posedge Clk); #1;
        a_req = 0; b_req = 0;
    endtask

    initial begin
        a_req = 1; b_req = 1; a_addr = 1; b_addr = 3;
        repeat (2) begin
            @(negedge Clk);
            chk("reset_outputs", {busy, a_ack, b_ack, rf_R_en, rf_W_en, rf_R_Addr, rf_W_Addr, rf_W_Data, a_rdata, b_rdata}, '0);
        end
        @(posedge Clk); #1;
        Rst = 1;
        sb.push_back('{1'b0, 32'h11, 32'h0});
        sb.push_back('{1'b1, 32'h11, 32'h33});
        sb.push_back('{1'b0, 32'h11, 32'h33});
        sb.push_back('{1'b1, 32'h11, 32'h33});
        exp_a = 32'h11; exp_b = 32'h33;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            chk($sformatf("rr_ack_cycle%0d", k), {a_ack, b_ack}, {k == 2 || k == 8, k == 5 || k == 11});
        end
        @(posedge Clk); #1;
        a_req = 0; b_req = 0;
        txn(0, 1, 2, 32'hDEADBEEF);
        txn(1, 0, 2, 0);
        for (int i = 0; i < 4; i++) txn(0, 1, 2'(i), i);
        for (int i = 0; i < 4; i++) txn(1, 0, 2'(i), 0);
        txn(0, 1, 1, 32'h11);
        a_req = 1; a_we = 1; a_addr = 1; a_wdata = 32'h55;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_access_wen", rf_W_en, 1'b1);
        #1 Rst = 0;
        #1 chk("abort_async_drop", {rf_W_en, busy, a_ack, a_rdata, b_rdata}, '0);
        a_req = 0;
        exp_a = 0; exp_b = 0;
        @(posedge Clk); #1;
        Rst = 1;
        txn(1, 0, 1, 0);
        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
